// File: rtl/rtc_bus_read_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_bus_read_ctrl
//
// Read-cycle initiator for the external RTC's multiplexed 8-bit address/data
// bus. One start pulse in IDLE produces one complete read:
//   address phase (setup / WR strobe / hold), bus turnaround,
//   data phase (setup / RD strobe / hold), then a one-cycle done pulse.
// The returned byte is captured on the edge that ends the RD strobe.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst       in   asynchronous reset, active low (0 = reset)
//   start     in   request one read, only sampled in IDLE
//   addr      in   RTC register address, latched when start is accepted
//   ad_in     in   byte returned by the RTC on the shared bus
//   ad_out    out  byte driven on the bus during the address phase
//   ad_oe     out  1 = this block drives the bus
//   a_d       out  0 = address phase, 1 = data phase
//   cs_n      out  chip select, active low
//   wr_n      out  write strobe, active low (address phase only)
//   rd_n      out  read strobe, active low
//   busy      out  1 while a transaction is in progress
//   done      out  one-cycle pulse, data_out is valid
//   data_out  out  last captured byte
//
// All outputs are registers. Their next values are decoded from the next
// state so each output changes on the same edge as the state it belongs to.
// -----------------------------------------------------------------------------
module rtc_bus_read_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADR_SETUP  = 3'd1,
        ADR_STROBE = 3'd2,
        ADR_HOLD   = 3'd3,
        DAT_SETUP  = 3'd4,
        DAT_STROBE = 3'd5,
        DAT_HOLD   = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic             phase_last_s;
    logic             capture_s;

    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       a_d_q, a_d_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] data_out_q, data_out_d;

    // Phase-end detect: the counter reaching (duration - 1) of the current state
    always_comb begin
        phase_last_s = 1'b1;
        case (state_q)
            ADR_SETUP, ADR_HOLD, DAT_SETUP, DAT_HOLD: phase_last_s = (cnt_q == SETUP_LAST);
            ADR_STROBE, DAT_STROBE:                   phase_last_s = (cnt_q == PULSE_LAST);
            default:                                  phase_last_s = 1'b1;
        endcase
    end

    // Next-state, phase counter and address latch
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADR_SETUP;
                    addr_d  = addr;
                end else begin
                    state_d = IDLE;
                end
            end
            ADR_SETUP: begin
                if (phase_last_s) state_d = ADR_STROBE;
                else              state_d = ADR_SETUP;
            end
            ADR_STROBE: begin
                if (phase_last_s) state_d = ADR_HOLD;
                else              state_d = ADR_STROBE;
            end
            ADR_HOLD: begin
                if (phase_last_s) state_d = DAT_SETUP;
                else              state_d = ADR_HOLD;
            end
            DAT_SETUP: begin
                if (phase_last_s) state_d = DAT_STROBE;
                else              state_d = DAT_SETUP;
            end
            DAT_STROBE: begin
                if (phase_last_s) state_d = DAT_HOLD;
                else              state_d = DAT_STROBE;
            end
            DAT_HOLD: begin
                if (phase_last_s) state_d = DONE;
                else              state_d = DAT_HOLD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state entry and rests at 0 while idle
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Output decode from the next state; bus is released before RD can strobe
    always_comb begin
        ad_out_d = 8'h00;
        ad_oe_d  = 1'b0;
        a_d_d    = 1'b0;
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ADR_SETUP, ADR_HOLD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                busy_d   = 1'b1;
            end
            ADR_STROBE: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                wr_n_d   = 1'b0;
                busy_d   = 1'b1;
            end
            DAT_SETUP, DAT_HOLD: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b1;
                busy_d = 1'b1;
            end
            DAT_STROBE: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b1;
                rd_n_d = 1'b0;
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: done_d = 1'b0;
        endcase

        // Capture on the edge that ends the final RD strobe cycle
        capture_s = (state_q == DAT_STROBE) && phase_last_s;
        if (capture_s) begin
            data_out_d = ad_in;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            a_d_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            a_d_q      <= a_d_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign a_d      = a_d_q;
    assign cs_n     = cs_n_q;
    assign wr_n     = wr_n_q;
    assign rd_n     = rd_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_rtc_bus_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_read_ctrl
//
// Scoreboard bench for rtc_bus_read_ctrl. Stimulus pushes the expected
// transaction (address, RTC byte, accept edge) into a queue; monitors sample
// at the falling edge, track strobe widths and protocol rules, and compare
// against the queue head whenever done pulses. A second instance runs with
// T_SETUP=1, T_PULSE=1.
// -----------------------------------------------------------------------------
module tb_rtc_bus_read_ctrl;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         acc;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;

    // default-parameter instance
    logic       start;
    logic [7:0] addr, ad_in, ad_out, data_out, rtc_data;
    logic       ad_oe, a_d, cs_n, wr_n, rd_n, busy, done;

    // fast instance
    logic       f_start;
    logic [7:0] f_addr, f_ad_in, f_ad_out, f_data_out, f_rtc_data;
    logic       f_ad_oe, f_a_d, f_cs_n, f_wr_n, f_rd_n, f_busy, f_done;

    int n_chk  = 0;
    int n_pass = 0;
    txn_t q[$];
    txn_t fq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC model: returns its byte only while RD is strobed
    assign ad_in   = rd_n   ? 8'hEE : rtc_data;
    assign f_ad_in = f_rd_n ? 8'hEE : f_rtc_data;

    rtc_bus_read_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs_n(cs_n), .wr_n(wr_n),
        .rd_n(rd_n), .busy(busy), .done(done), .data_out(data_out)
    );

    rtc_bus_read_ctrl #(.T_SETUP(1), .T_PULSE(1), .CNT_W(4)) u_dut_fast (
        .clk(clk), .rst(rst), .start(f_start), .addr(f_addr), .ad_in(f_ad_in),
        .ad_out(f_ad_out), .ad_oe(f_ad_oe), .a_d(f_a_d), .cs_n(f_cs_n), .wr_n(f_wr_n),
        .rd_n(f_rd_n), .busy(f_busy), .done(f_done), .data_out(f_data_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [22:0] outvec();
        return {cs_n, wr_n, rd_n, a_d, ad_oe, busy, done, ad_out, data_out};
    endfunction

    localparam logic [22:0] RESET_VEC = {7'b1110000, 8'h00, 8'h00};

    // Main monitor: per-transaction tracking, compare at done
    initial begin : mon_main
        int wr_lo, rd_lo, cs_lo, cs_falls, viol, bad_addr;
        logic cs_prev;
        txn_t t;
        wr_lo = 0; rd_lo = 0; cs_lo = 0; cs_falls = 0; viol = 0; bad_addr = 0;
        cs_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_lo = 0; rd_lo = 0; cs_lo = 0; cs_falls = 0; viol = 0; bad_addr = 0;
                cs_prev = 1'b1;
            end else begin
                if (!wr_n) begin
                    wr_lo++;
                    if (q.size() > 0 && ad_out !== q[0].a) bad_addr++;
                end
                if (!rd_n) rd_lo++;
                if (!cs_n) begin
                    cs_lo++;
                    if (cs_prev) cs_falls++;
                end
                cs_prev = cs_n;
                if ((!wr_n && !rd_n) || (ad_oe && !rd_n)) viol++;
                if (done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        t = q.pop_front();
                        check("data_out", {24'd0, data_out}, {24'd0, t.d});
                        check("done_latency", cyc - t.acc, 32'd16);
                        check("wr_n_width", wr_lo, 32'd4);
                        check("rd_n_width", rd_lo, 32'd4);
                        check("cs_n_low_cycles", cs_lo, 32'd16);
                        check("cs_n_contiguous", cs_falls, 32'd1);
                        check("protocol_viol", viol, 32'd0);
                        check("addr_driven", bad_addr, 32'd0);
                        check("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                    wr_lo = 0; rd_lo = 0; cs_lo = 0; cs_falls = 0; viol = 0; bad_addr = 0;
                end
            end
        end
    end

    // Fast-instance monitor
    initial begin : mon_fast
        int wr_lo, rd_lo;
        txn_t t;
        wr_lo = 0; rd_lo = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_lo = 0; rd_lo = 0;
            end else begin
                if (!f_wr_n) wr_lo++;
                if (!f_rd_n) rd_lo++;
                if (f_done) begin
                    if (fq.size() == 0) begin
                        check("fast_unexpected_done", 32'd1, 32'd0);
                    end else begin
                        t = fq.pop_front();
                        check("fast_data_out", {24'd0, f_data_out}, {24'd0, t.d});
                        check("fast_latency", cyc - t.acc, 32'd6);
                        check("fast_wr_width", wr_lo, 32'd1);
                        check("fast_rd_width", rd_lo, 32'd1);
                    end
                    wr_lo = 0; rd_lo = 0;
                end
            end
        end
    end

    task automatic wait_done(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        @(negedge clk);
        rtc_data = d;
        addr     = a;
        start    = 1'b1;
        t.a = a; t.d = d; t.acc = cyc + 1;
        q.push_back(t);
        @(negedge clk);
        start = 1'b0;
        wait_done("timeout_done", 40);
        @(negedge clk);
    endtask

    task automatic do_read_fast(input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        @(negedge clk);
        f_rtc_data = d;
        f_addr     = a;
        f_start    = 1'b1;
        t.a = a; t.d = d; t.acc = cyc + 1;
        fq.push_back(t);
        @(negedge clk);
        f_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (f_done) break;
            if (i == 19) check("fast_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin : stim
        txn_t t;
        int   c0;
        int   dones;
        start = 1'b0; addr = 8'h00; rtc_data = 8'h00;
        f_start = 1'b0; f_addr = 8'h00; f_rtc_data = 8'h00;
        rst = 1'b0;

        // reset then idle
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {9'd0, outvec()}, {9'd0, RESET_VEC});
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {9'd0, outvec()}, {9'd0, RESET_VEC});
        end

        // single read with defaults
        do_read(8'h21, 8'h59);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("data_out_hold", {24'd0, data_out}, 32'h59);

        // start held high, addr toggling: first txn uses 0x21, second starts 18 edges later
        @(negedge clk);
        rtc_data = 8'h59;
        addr     = 8'h21;
        start    = 1'b1;
        c0 = cyc + 1;
        t.a = 8'h21; t.d = 8'h59; t.acc = c0;      q.push_back(t);
        t.a = 8'h22; t.d = 8'h59; t.acc = c0 + 18; q.push_back(t);
        for (int k = 1; k < 30; k++) begin
            @(negedge clk);
            addr = k[0] ? 8'h21 : 8'h22;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("timeout_second", 40);
        @(negedge clk);

        // 50 random reads
        for (int n = 0; n < 50; n++) begin
            do_read(8'($urandom_range(255)), 8'($urandom_range(255)));
        end

        // reset during DAT_STROBE
        do_read(8'h5A, 8'hA5);
        @(negedge clk);
        addr = 8'h33; rtc_data = 8'h44; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!rd_n) break;
            @(negedge clk);
        end
        check("reached_dat_strobe", {31'd0, rd_n}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("async_rst_rd_n", {31'd0, rd_n}, 32'd1);
        check("async_rst_ad_oe", {31'd0, ad_oe}, 32'd0);
        check("async_rst_data_out", {24'd0, data_out}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_reset", dones, 32'd0);
        do_read(8'h7E, 8'h81);

        // fast instance
        do_read_fast(8'h10, 8'h3C);
        do_read_fast(8'hF0, 8'hC3);
        do_read_fast(8'h01, 8'h80);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        check("fast_queue_drained", fq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rtc_bus_read_ctrl.md
Name: rtc_bus_read_ctrl

Overview:
- Read-cycle initiator for the multiplexed 8-bit address/data bus of the external RTC.
- It is the reading counterpart of the register and write path: given a register address, it drives the address phase, turns the bus around, strobes RD, and captures the returned byte.
- It sits between the top-level controller FSM and the RTC pins.
- It performs one transaction per start pulse.

Parameters:
- T_SETUP, 2: cycles for each setup or hold phase around a strobe. Must be ≥1.
- T_PULSE, 4: cycles each WR or RD strobe is held low. Must be ≥1.
- CNT_W, 4: phase counter width. Must satisfy 2^CNT_W > max(T_SETUP, T_PULSE).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request one read; sampled only in IDLE.
- addr  in  8  RTC register address; latched when start is accepted.
- ad_in  in  8  bus value returned by the RTC.
- ad_out  out  8  bus value driven during the address phase.
- ad_oe  out  1  1 = block drives the bus (tristate enable at top level).
- a_d  out  1  0 = address phase, 1 = data phase.
- cs_n  out  1  chip select, active-low.
- wr_n  out  1  write strobe, active-low; pulses only in the address phase.
- rd_n  out  1  read strobe, active-low.
- busy  out  1  1 while a transaction is in progress.
- done  out  1  one-cycle pulse; data_out is valid.
- data_out  out  8  last captured byte.

Behaviour:
- Reset (rst=0, asynchronous) forces the following immediately, regardless of clk:
  - state=IDLE, counter=0;
  - cs_n=1, wr_n=1, rd_n=1, a_d=0;
  - ad_oe=0, ad_out=0, busy=0, done=0, data_out=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States, their durations, and the outputs in each:
  - IDLE: all control inactive (as at reset). start=1 at an edge latches addr, sets busy=1, and goes to ADR_SETUP.
  - ADR_SETUP (T_SETUP cycles): cs_n=0, a_d=0, ad_oe=1, ad_out=latched addr.
  - ADR_STROBE (T_PULSE cycles): as ADR_SETUP, plus wr_n=0.
  - ADR_HOLD (T_SETUP cycles): wr_n=1, address still driven.
  - DAT_SETUP (T_SETUP cycles): ad_oe=0, ad_out=0, a_d=1, cs_n stays 0. Bus turnaround; never drive and strobe RD together.
  - DAT_STROBE (T_PULSE cycles): rd_n=0. On the edge that ends the last strobe cycle, data_out<=ad_in.
  - DAT_HOLD (T_SETUP cycles): rd_n=1, cs_n=0, a_d=1.
  - DONE (1 cycle): cs_n=1, a_d=0, busy=0, done=1. Then return to IDLE.
- Phase counter: reloads to 0 on each state entry and advances the state when it reaches (duration-1).
- Latency: with start accepted at edge E0, done is high from edge E(4*T_SETUP+2*T_PULSE) to the next edge. With defaults that is E16.
- busy is high from E0 until done asserts.
- Back-to-back: start=1 during the DONE cycle is ignored. The next start is accepted in IDLE, so transactions have a minimum 1-cycle idle gap.
- start=1 while busy has no effect; addr changes while busy have no effect.
- cs_n stays continuously low from ADR_SETUP through DAT_HOLD; there is no glitch at the phase boundary.
- wr_n and rd_n are never low simultaneously.
- ad_oe=1 is never concurrent with rd_n=0.
- data_out holds its value until the next capture or reset.
- Reset mid-transaction: the bus is released immediately, no done pulse is emitted, and data_out is cleared to 0.

Test Plan:
- Reset then idle: rst=0 then 1, no start → all outputs at reset values for 20 cycles; cs_n=1, ad_oe=0.
- Single read, defaults: start=1, addr=0x21, RTC model returns ad_in=0x59 while rd_n=0 →
  - ad_out=0x21 with wr_n low for exactly 4 cycles;
  - rd_n low for 4 cycles;
  - done pulse at E16, data_out=0x59, busy low after.
- Ignored start: start held high for 30 cycles with addr toggled 0x21/0x22 mid-transaction →
  - only address 0x21 is driven in the first transaction;
  - the second transaction begins in the cycle after IDLE is re-entered.
- Protocol checker across 50 random reads (random addr/ad_in) →
  - wr_n/rd_n never both low;
  - ad_oe never 1 while rd_n=0;
  - cs_n low contiguous per transaction;
  - data_out matches model.
- Reset mid-operation: assert rst during DAT_STROBE →
  - cs_n=1, rd_n=1, ad_oe=0, data_out=0 without waiting for clk;
  - no done pulse;
  - next start completes normally.
- Parameter override T_SETUP=1, T_PULSE=1 → done at E6; strobes exactly one cycle wide.
